// File: rtl/mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
// Shared constants and helpers for the modulo-N event counter family.
//   DEFAULT_WIDTH / DEFAULT_MODULUS : default parameter values for counters
//   wideT                           : generous fixed-width carrier type used by
//                                     the helpers so any WIDTH up to 32 fits
//   terminalValue(lim, up)          : value at which a terminal event fires
//   startValue(lim, up)             : value the count restarts from
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_MODULUS = 10000;
  localparam int MAX_WIDTH       = 32;

  typedef logic [MAX_WIDTH-1:0] wideT;

  // Counting up ends at limit-1; counting down ends at 0.
  function automatic wideT terminalValue(input wideT lim, input logic up);
    return up ? (lim - wideT'(1)) : '0;
  endfunction

  // Counting up starts at 0; counting down starts at limit-1.
  function automatic wideT startValue(input wideT lim, input logic up);
    return up ? '0 : (lim - wideT'(1));
  endfunction

endpackage

// File: rtl/mod_counter_gen.sv
// ---------------------------------------------------------------------------
// mod_counter_gen
// Modulo-N event counter with a runtime-loadable limit, up/down direction,
// wrap or one-shot mode, a registered cascade carry pulse and a done flag.
//
// Parameters
//   WIDTH    : width of count, limit and limitIn
//   MODULUS  : limit value after reset (1 .. 2^WIDTH-1)
// Ports
//   tick      in   : clock, rising edge
//   reset     in   : synchronous active-high reset
//   enable    in   : count enable
//   clear     in   : return count to the start value, clears done
//   up        in   : 1 = count up, 0 = count down
//   oneShot   in   : 1 = stop at terminal value, 0 = wrap
//   loadLimit in   : load limitIn into the limit register
//   limitIn   in   : new limit (0 is treated as 1)
//   count     out  : current count (registered)
//   limit     out  : current limit (registered)
//   reached   out  : count equals the terminal value (combinational)
//   carry     out  : one-cycle pulse after each terminal event (registered)
//   done      out  : one-shot finished (registered level)
// Cascade stages externally by feeding carry into the next stage's enable.
// ---------------------------------------------------------------------------
module mod_counter_gen
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MODULUS = DEFAULT_MODULUS
) (
  input  logic             tick,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             up,
  input  logic             oneShot,
  input  logic             loadLimit,
  input  logic [WIDTH-1:0] limitIn,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             reached,
  output logic             carry,
  output logic             done
);

  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] newLimit;
  logic [WIDTH-1:0] loadStart;
  logic [WIDTH-1:0] resetCount;

  // Terminal and start values follow the live up input, so a direction
  // change simply continues from the present count on the next enabled tick.
  assign terminal = WIDTH'(terminalValue(wideT'(limit), up));
  assign start    = WIDTH'(startValue(wideT'(limit), up));

  // A zero limit would leave no legal count value, so it is clamped to 1.
  assign newLimit  = (limitIn == '0) ? WIDTH'(1) : limitIn;
  assign loadStart = WIDTH'(startValue(wideT'(newLimit), up));

  assign resetCount = up ? '0 : WIDTH'(MODULUS - 1);

  assign reached = (count == terminal);

  // Register update with priority reset > loadLimit > clear > enable > hold.
  // Once done is set the counter is frozen until reset, clear or a load.
  always_ff @(posedge tick) begin
    if (reset) begin
      limit <= WIDTH'(MODULUS);
      count <= resetCount;
      carry <= 1'b0;
      done  <= 1'b0;
    end else if (loadLimit) begin
      limit <= newLimit;
      count <= loadStart;
      carry <= 1'b0;
      done  <= 1'b0;
    end else if (clear) begin
      count <= start;
      carry <= 1'b0;
      done  <= 1'b0;
    end else if (enable && !done) begin
      if (count == terminal) begin
        carry <= 1'b1;
        if (oneShot) begin
          done <= 1'b1;
        end else begin
          count <= start;
        end
      end else begin
        carry <= 1'b0;
        count <= up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      end
    end else begin
      carry <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter_gen.sv
// ---------------------------------------------------------------------------
// tb_mod_counter_gen
// Directed testbench for mod_counter_gen: one main instance with default
// parameters and a two-stage cascade of modulo-10 instances.
// ---------------------------------------------------------------------------
module tb_mod_counter_gen;

  logic        tick;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        up;
  logic        oneShot;
  logic        loadLimit;
  logic [15:0] limitIn;
  logic [15:0] count;
  logic [15:0] limit;
  logic        reached;
  logic        carry;
  logic        done;

  // Cascade signals
  logic       casReset;
  logic       casEnable;
  logic       casZero;
  logic       casOne;
  logic [7:0] casLimitIn;
  logic [7:0] aCount, aLimit, bCount, bLimit;
  logic       aReached, aCarry, aDone, bReached, bCarry, bDone;

  int errors = 0;
  int checks = 0;

  mod_counter_gen dut (
    .tick(tick), .reset(reset), .enable(enable), .clear(clear), .up(up),
    .oneShot(oneShot), .loadLimit(loadLimit), .limitIn(limitIn),
    .count(count), .limit(limit), .reached(reached), .carry(carry), .done(done)
  );

  mod_counter_gen #(.WIDTH(8), .MODULUS(10)) casA (
    .tick(tick), .reset(casReset), .enable(casEnable), .clear(casZero), .up(casOne),
    .oneShot(casZero), .loadLimit(casZero), .limitIn(casLimitIn),
    .count(aCount), .limit(aLimit), .reached(aReached), .carry(aCarry), .done(aDone)
  );

  mod_counter_gen #(.WIDTH(8), .MODULUS(10)) casB (
    .tick(tick), .reset(casReset), .enable(aCarry), .clear(casZero), .up(casOne),
    .oneShot(casZero), .loadLimit(casZero), .limitIn(casLimitIn),
    .count(bCount), .limit(bLimit), .reached(bReached), .carry(bCarry), .done(bDone)
  );

  // Free-running clock
  initial tick = 1'b0;
  always #5 tick = ~tick;

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge tick);
    #1;
  endtask

  // Reset values for both directions; enable is ignored during reset
  task automatic test_reset();
    reset = 1'b1; up = 1'b1; enable = 1'b1;
    step();
    checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    checks++; if (limit !== 16'd10000) begin errors++; $display("[TB] FAIL reset_limit got=%0d exp=10000", limit); end
    checks++; if (carry !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got carry=%b done=%b exp 0 0", carry, done); end
    checks++; if (reached !== 1'b0) begin errors++; $display("[TB] FAIL reset_reached got=%b exp=0", reached); end
    up = 1'b0;
    step();
    checks++; if (count !== 16'd9999) begin errors++; $display("[TB] FAIL reset_down_count got=%0d exp=9999", count); end
    up = 1'b1;
    step();
    reset = 1'b0; enable = 1'b0;
  endtask

  // 20000 enabled ticks in wrap mode at the default modulus
  task automatic test_wrap_long();
    int expCount = 0;
    int badCount = 0;
    int wraps = 0, carries = 0, carryBad = 0, reachedCnt = 0;
    logic [15:0] prevCount;
    up = 1'b1; oneShot = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 20000; k++) begin
      prevCount = count;
      step();
      expCount = (expCount == 9999) ? 0 : expCount + 1;
      if (count !== 16'(expCount)) badCount++;
      if (prevCount == 16'd9999 && count == 16'd0) wraps++;
      if (carry === 1'b1) begin
        carries++;
        if (prevCount != 16'd9999) carryBad++;
      end
      if (reached === 1'b1) reachedCnt++;
    end
    enable = 1'b0;
    checks++; if (badCount != 0) begin errors++; $display("[TB] FAIL wrap_count_seq bad=%0d exp=0", badCount); end
    checks++; if (wraps != 2) begin errors++; $display("[TB] FAIL wrap_events got=%0d exp=2", wraps); end
    checks++; if (carries != 2) begin errors++; $display("[TB] FAIL wrap_carries got=%0d exp=2", carries); end
    checks++; if (carryBad != 0) begin errors++; $display("[TB] FAIL wrap_carry_timing bad=%0d exp=0", carryBad); end
    checks++; if (reachedCnt != 2) begin errors++; $display("[TB] FAIL wrap_reached got=%0d exp=2", reachedCnt); end
  endtask

  // Load limit 5 mid-count, then count down in one-shot mode
  task automatic test_oneshot_down();
    int expSeq [4] = '{3, 2, 1, 0};
    enable = 1'b1; up = 1'b1; oneShot = 1'b0;
    repeat (3) step();
    loadLimit = 1'b1; limitIn = 16'd5; up = 1'b0; oneShot = 1'b1;
    step();
    loadLimit = 1'b0;
    checks++; if (count !== 16'd4 || limit !== 16'd5) begin errors++; $display("[TB] FAIL load5 got count=%0d limit=%0d exp 4 5", count, limit); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (count !== 16'(expSeq[i]) || carry !== 1'b0) begin errors++; $display("[TB] FAIL down_seq%0d got count=%0d carry=%b exp %0d 0", i, count, carry, expSeq[i]); end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("[TB] FAIL down_reached got=%b exp=1", reached); end
    step();
    checks++; if (done !== 1'b1 || carry !== 1'b1 || count !== 16'd0) begin errors++; $display("[TB] FAIL oneshot_hit got done=%b carry=%b count=%0d exp 1 1 0", done, carry, count); end
    step();
    checks++; if (done !== 1'b1 || carry !== 1'b0 || count !== 16'd0) begin errors++; $display("[TB] FAIL oneshot_hold got done=%b carry=%b count=%0d exp 1 0 0", done, carry, count); end
    oneShot = 1'b0;
    step();
    checks++; if (done !== 1'b1 || count !== 16'd0) begin errors++; $display("[TB] FAIL oneshot_sticky got done=%b count=%0d exp 1 0", done, count); end
    clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b0;
    checks++; if (count !== 16'd4 || done !== 1'b0) begin errors++; $display("[TB] FAIL clear_restore got count=%0d done=%b exp 4 0", count, done); end
  endtask

  // limitIn of zero is clamped to one
  task automatic test_limit_zero();
    up = 1'b1; oneShot = 1'b0; enable = 1'b0;
    loadLimit = 1'b1; limitIn = 16'd0;
    step();
    loadLimit = 1'b0;
    checks++; if (limit !== 16'd1 || count !== 16'd0 || reached !== 1'b1) begin errors++; $display("[TB] FAIL limit0_load got limit=%0d count=%0d reached=%b exp 1 0 1", limit, count, reached); end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (carry !== 1'b1 || count !== 16'd0) begin errors++; $display("[TB] FAIL limit1_wrap%0d got carry=%b count=%0d exp 1 0", i, carry, count); end
    end
    enable = 1'b0;
    step();
    checks++; if (carry !== 1'b0) begin errors++; $display("[TB] FAIL limit1_idle got carry=%b exp=0", carry); end
    oneShot = 1'b1; enable = 1'b1;
    step();
    checks++; if (done !== 1'b1 || carry !== 1'b1) begin errors++; $display("[TB] FAIL limit1_oneshot got done=%b carry=%b exp 1 1", done, carry); end
    enable = 1'b0; oneShot = 1'b0;
  endtask

  // Simultaneous control inputs resolve by priority
  task automatic test_simultaneous();
    up = 1'b1; oneShot = 1'b0;
    loadLimit = 1'b1; limitIn = 16'd10; enable = 1'b0;
    step();
    loadLimit = 1'b0; enable = 1'b1;
    repeat (3) step();
    checks++; if (count !== 16'd3) begin errors++; $display("[TB] FAIL pre_sim_count got=%0d exp=3", count); end
    loadLimit = 1'b1; clear = 1'b1; limitIn = 16'd20;
    step();
    loadLimit = 1'b0; clear = 1'b0;
    checks++; if (count !== 16'd0 || limit !== 16'd20 || carry !== 1'b0) begin errors++; $display("[TB] FAIL load_clear_en got count=%0d limit=%0d carry=%b exp 0 20 0", count, limit, carry); end
    repeat (2) step();
    reset = 1'b1; loadLimit = 1'b1; limitIn = 16'd7;
    step();
    reset = 1'b0; loadLimit = 1'b0; enable = 1'b0;
    checks++; if (count !== 16'd0 || limit !== 16'd10000) begin errors++; $display("[TB] FAIL reset_load got count=%0d limit=%0d exp 0 10000", count, limit); end
  endtask

  // Direction flip at 7 with limit 10, then gated enable
  task automatic test_direction_flip();
    int toggleEn  [4] = '{1, 0, 1, 0};
    int toggleExp [4] = '{8, 8, 7, 7};
    up = 1'b1; oneShot = 1'b0;
    loadLimit = 1'b1; limitIn = 16'd10;
    step();
    loadLimit = 1'b0; enable = 1'b1;
    repeat (7) step();
    checks++; if (count !== 16'd7) begin errors++; $display("[TB] FAIL flip_start got=%0d exp=7", count); end
    up = 1'b0;
    for (int e = 6; e >= 0; e--) begin
      step();
      checks++; if (count !== 16'(e)) begin errors++; $display("[TB] FAIL flip_down got=%0d exp=%0d", count, e); end
    end
    checks++; if (reached !== 1'b1) begin errors++; $display("[TB] FAIL flip_reached got=%b exp=1", reached); end
    step();
    checks++; if (count !== 16'd9 || carry !== 1'b1) begin errors++; $display("[TB] FAIL flip_wrap got count=%0d carry=%b exp 9 1", count, carry); end
    for (int i = 0; i < 4; i++) begin
      enable = toggleEn[i][0];
      step();
      checks++; if (count !== 16'(toggleExp[i]) || carry !== 1'b0) begin errors++; $display("[TB] FAIL toggle%0d got count=%0d carry=%b exp %0d 0", i, count, carry, toggleExp[i]); end
    end
    enable = 1'b0;
  endtask

  // Two modulo-10 stages; each stage adds one edge of carry latency,
  // so stage B's terminal event lands on the edge after the 100th tick.
  task automatic test_cascade();
    int bCarries = 0;
    casReset = 1'b1;
    step();
    casReset = 1'b0; casEnable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (bCarry === 1'b1) bCarries++;
    end
    casEnable = 1'b0;
    checks++; if (aCount !== 8'd0 || bCount !== 8'd9) begin errors++; $display("[TB] FAIL cascade_100 got a=%0d b=%0d exp 0 9", aCount, bCount); end
    checks++; if (aCarry !== 1'b1) begin errors++; $display("[TB] FAIL cascade_a_carry got=%b exp=1", aCarry); end
    step();
    if (bCarry === 1'b1) bCarries++;
    checks++; if (bCount !== 8'd0 || bCarry !== 1'b1) begin errors++; $display("[TB] FAIL cascade_b_wrap got count=%0d carry=%b exp 0 1", bCount, bCarry); end
    repeat (8) begin
      step();
      if (bCarry === 1'b1) bCarries++;
    end
    checks++; if (bCarries != 1) begin errors++; $display("[TB] FAIL cascade_b_carries got=%0d exp=1", bCarries); end
  endtask

  // Test sequence
  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; up = 1'b1; oneShot = 1'b0;
    loadLimit = 1'b0; limitIn = '0;
    casReset = 1'b1; casEnable = 1'b0; casZero = 1'b0; casOne = 1'b1; casLimitIn = '0;
    test_reset();
    test_wrap_long();
    test_oneshot_down();
    test_limit_zero();
    test_simultaneous();
    test_direction_flip();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
